// File: rtl/itcm_ctrl.sv
// Instruction TCM controller: single-port fetch with in-order response FIFO, byte-masked load port.
// Optional per-byte even parity is enabled by defining ITCM_PARITY_EN (adds wr_par_flip input).
module itcm_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_gnt,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_err,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
`ifdef ITCM_PARITY_EN
  input  logic                    wr_par_flip,
`endif
  output logic                    busy
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int IW        = $clog2(DEPTH);
  localparam int RSP_DEPTH = RD_LATENCY + 1;
  localparam int OW        = $clog2(RSP_DEPTH + 1);
  localparam int PW        = $clog2(RSP_DEPTH);
  localparam int PIPE_N    = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef ITCM_PARITY_EN
  logic [NB-1:0]         par_mem [DEPTH];
`endif

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> (IW + 2)) == '0);
  endfunction

  logic [IW-1:0]         rd_idx, wr_idx;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] rd_word, s_data;
  logic                  s_err, par_bad;
  logic [OW-1:0]         occ;
  logic                  pop;

  assign rd_idx = rd_addr[IW+1:2];
  assign wr_idx = wr_addr[IW+1:2];
  assign rd_ok  = addr_ok(rd_addr);
  assign wr_ok  = addr_ok(wr_addr);
  assign rd_gnt = rd_req && !rst && (occ < OW'(RSP_DEPTH));
  assign busy   = (occ != '0);

  // Memory is read combinationally in the grant cycle, so a same-cycle write lands after the read.
  always_comb begin
    rd_word = mem[rd_idx];
    par_bad = 1'b0;
    s_data  = '0;
    s_err   = 1'b1;
`ifdef ITCM_PARITY_EN
    for (int unsigned b = 0; b < NB; b++) begin
      if ((^rd_word[8*b +: 8]) != par_mem[rd_idx][b]) par_bad = 1'b1;
    end
`endif
    if (rd_ok) begin
      s_data = rd_word;
      s_err  = par_bad;
    end
  end

  // Contents are intentionally not reset so code survives rst.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
`ifdef ITCM_PARITY_EN
          par_mem[wr_idx][b] <= (^wr_data[8*b +: 8]) ^ wr_par_flip;
`endif
        end
      end
    end
  end

  logic                  p_v [PIPE_N];
  logic [DATA_WIDTH-1:0] p_d [PIPE_N];
  logic                  p_e [PIPE_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_N; i++) begin
        p_v[i] <= 1'b0;
        p_d[i] <= '0;
        p_e[i] <= 1'b0;
      end
    end else begin
      p_v[0] <= rd_gnt;
      p_d[0] <= s_data;
      p_e[0] <= s_err;
      for (int unsigned i = 1; i < PIPE_N; i++) begin
        p_v[i] <= p_v[i-1];
        p_d[i] <= p_d[i-1];
        p_e[i] <= p_e[i-1];
      end
    end
  end

  // With one cycle of latency the grant-cycle read feeds the FIFO directly.
  logic                  f_v, f_e;
  logic [DATA_WIDTH-1:0] f_d;
  assign f_v = (RD_LATENCY == 1) ? rd_gnt : p_v[PIPE_N-1];
  assign f_d = (RD_LATENCY == 1) ? s_data : p_d[PIPE_N-1];
  assign f_e = (RD_LATENCY == 1) ? s_err  : p_e[PIPE_N-1];

  logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
  logic                  fifo_e [RSP_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [OW-1:0]         cnt;

  assign rd_valid = (cnt != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? fifo_d[rptr] : '0;
  assign rd_err   = rd_valid ? fifo_e[rptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (f_v) begin
      fifo_d[wptr] <= f_d;
      fifo_e[wptr] <= f_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      occ  <= '0;
    end else begin
      if (f_v) wptr <= (wptr == PW'(RSP_DEPTH - 1)) ? '0 : wptr + PW'(1);
      if (pop) rptr <= (rptr == PW'(RSP_DEPTH - 1)) ? '0 : rptr + PW'(1);
      case ({f_v, pop})
        2'b10:   cnt <= cnt + OW'(1);
        2'b01:   cnt <= cnt - OW'(1);
        default: cnt <= cnt;
      endcase
      case ({rd_gnt, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_itcm_ctrl.sv
// Directed bench for itcm_ctrl: a RD_LATENCY=1 and a RD_LATENCY=3 instance share clock and reset.
module tb_itcm_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rd_req, rd_gnt, rd_valid, rd_ready, rd_err, wr_en, busy;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        b_rd_req, b_rd_gnt, b_rd_valid, b_rd_ready, b_rd_err, b_wr_en, b_busy;
  logic [31:0] b_rd_addr, b_rd_data, b_wr_addr, b_wr_data;
  logic [3:0]  b_wr_strb;
`ifdef ITCM_PARITY_EN
  logic        par_flip, b_par_flip;
`endif

  itcm_ctrl #(.DEPTH(1024), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
`ifdef ITCM_PARITY_EN
    .wr_par_flip(par_flip),
`endif
    .busy(busy));

  itcm_ctrl #(.DEPTH(1024), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .rd_err(b_rd_err),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_strb(b_wr_strb),
`ifdef ITCM_PARITY_EN
    .wr_par_flip(b_par_flip),
`endif
    .busy(b_busy));

  // Stimulus helpers: enter and leave on a falling edge.
  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr3(input logic [31:0] a, input logic [31:0] d);
    b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d; b_wr_strb = 4'hF;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic rd1(input logic [31:0] a, output logic g, output logic v,
                     output logic [31:0] d, output logic e);
    rd_req = 1'b1; rd_addr = a; rd_ready = 1'b1;
    #1 g = rd_gnt;
    @(negedge clk);
    rd_req = 1'b0;
    v = rd_valid; d = rd_data; e = rd_err;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rd_req = 1'b1; b_rd_req = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", rd_gnt); end
    checks++; if (b_rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt3 got %b exp 0", b_rd_gnt); end
    checks++; if ({rd_valid, rd_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {rd_valid, rd_err, busy}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", rd_data); end
    rd_req = 1'b0; b_rd_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    wr1(32'h000, 32'h0000_0013, 4'hF);
    wr1(32'h004, 32'hDEAD_BEEF, 4'hF);
    rd_req = 1'b1; rd_addr = 32'h000; rd_ready = 1'b1;
    #1;
    checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0 got %b exp 1", rd_gnt); end
    @(negedge clk);
    checks++; if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 32'h0000_0013}) begin
      errors++; $display("FAIL b2b_rsp0 got v%b e%b %h exp v1 e0 00000013", rd_valid, rd_err, rd_data); end
    rd_addr = 32'h004;
    #1;
    checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1 got %b exp 1", rd_gnt); end
    @(negedge clk);
    rd_req = 1'b0;
    checks++; if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL b2b_rsp1 got v%b e%b %h exp v1 e0 deadbeef", rd_valid, rd_err, rd_data); end
    @(negedge clk);
    checks++; if ({rd_valid, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {rd_valid, busy}); end
  endtask

  task automatic test_illegal;
    logic g, v, e; logic [31:0] d;
    rd1(32'h002, g, v, d, e);
    checks++; if ({g, v, e, d} !== {3'b111, 32'h0}) begin
      errors++; $display("FAIL illegal_misaligned got g%b v%b e%b %h exp g1 v1 e1 00000000", g, v, e, d); end
    rd1(32'h1000, g, v, d, e);
    checks++; if ({g, v, e, d} !== {3'b111, 32'h0}) begin
      errors++; $display("FAIL illegal_range got g%b v%b e%b %h exp g1 v1 e1 00000000", g, v, e, d); end
    rd1(32'hFFC, g, v, d, e);
    checks++; if ({v, e} !== 2'b10) begin errors++; $display("FAIL last_word_err got v%b e%b exp v1 e0", v, e); end
  endtask

  task automatic test_strobe;
    logic g, v, e; logic [31:0] d;
    wr1(32'h010, 32'h1122_3344, 4'hF);
    wr1(32'h010, 32'h0000_AB00, 4'b0010);
    rd1(32'h010, g, v, d, e);
    checks++; if ({v, e, d} !== {2'b10, 32'h1122_AB44}) begin
      errors++; $display("FAIL strobe_merge got v%b e%b %h exp v1 e0 1122ab44", v, e, d); end
    wr1(32'h1010, 32'hFFFF_FFFF, 4'hF);
    wr1(32'h012, 32'hFFFF_FFFF, 4'hF);
    rd1(32'h010, g, v, d, e);
    checks++; if (d !== 32'h1122_AB44) begin errors++; $display("FAIL illegal_write_ignored got %h exp 1122ab44", d); end
  endtask

  task automatic test_rbw;
    logic g, v, e; logic [31:0] d;
    wr1(32'h020, 32'hA5A5_A5A5, 4'hF);
    rd_req = 1'b1; rd_addr = 32'h020; rd_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h020; wr_data = 32'h5A5A_5A5A; wr_strb = 4'hF;
    @(negedge clk);
    rd_req = 1'b0; wr_en = 1'b0;
    checks++; if ({rd_valid, rd_data} !== {1'b1, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL rbw_old got v%b %h exp v1 a5a5a5a5", rd_valid, rd_data); end
    @(negedge clk);
    rd1(32'h020, g, v, d, e);
    checks++; if (d !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rbw_new got %h exp 5a5a5a5a", d); end
  endtask

  task automatic test_backpressure;
    int grants = 0;
    int first_v = -1;
    logic last_gnt = 1'b1;
    for (int i = 0; i < 6; i++) wr3(32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    b_rd_ready = 1'b0; b_rd_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (b_rd_valid && first_v < 0) first_v = c;
      b_rd_addr = 32'h40 + 32'(4 * grants);
      #1;
      last_gnt = b_rd_gnt;
      if (b_rd_gnt) grants++;
      @(negedge clk);
    end
    b_rd_req = 1'b0;
    checks++; if (grants !== 4) begin errors++; $display("FAIL bp_grant_count got %0d exp 4", grants); end
    checks++; if (last_gnt !== 1'b0) begin errors++; $display("FAIL bp_gnt_blocked got %b exp 0", last_gnt); end
    checks++; if (first_v !== 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", first_v); end
    checks++; if ({b_rd_valid, b_busy, b_rd_data} !== {2'b11, 32'h1000_0000}) begin
      errors++; $display("FAIL bp_hold got v%b busy%b %h exp v1 busy1 10000000", b_rd_valid, b_busy, b_rd_data); end
    b_rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({b_rd_valid, b_rd_err, b_rd_data} !== {2'b10, 32'h1000_0000 + 32'(i)}) begin
        errors++; $display("FAIL bp_drain%0d got v%b e%b %h exp v1 e0 %h", i, b_rd_valid, b_rd_err, b_rd_data, 32'h1000_0000 + 32'(i)); end
      @(negedge clk);
    end
    checks++; if ({b_rd_valid, b_busy} !== 2'b00) begin errors++; $display("FAIL bp_empty got %b exp 00", {b_rd_valid, b_busy}); end
  endtask

  task automatic test_reset_inflight;
    logic seen = 1'b0;
    logic got = 1'b0;
    logic g, v, e; logic [31:0] d;
    b_rd_ready = 1'b0; b_rd_req = 1'b1; b_rd_addr = 32'h44;
    repeat (3) @(negedge clk);
    b_rd_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({b_rd_valid, b_busy, b_rd_err} !== 3'b000) begin
      errors++; $display("FAIL rst_inflight_during got %b exp 000", {b_rd_valid, b_busy, b_rd_err}); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    b_rd_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (b_rd_valid || b_busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_inflight_discard got %b exp 0", seen); end
    b_rd_req = 1'b1; b_rd_addr = 32'h40;
    #1;
    checks++; if (b_rd_gnt !== 1'b1) begin errors++; $display("FAIL rst_post_gnt got %b exp 1", b_rd_gnt); end
    @(negedge clk);
    b_rd_req = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (b_rd_valid) begin
        got = 1'b1;
        checks++; if ({b_rd_err, b_rd_data} !== {1'b0, 32'h1000_0000}) begin
          errors++; $display("FAIL rst_preserved3 got e%b %h exp e0 10000000", b_rd_err, b_rd_data); end
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++; errors++; $display("FAIL rst_post_timeout got no rd_valid exp rd_valid within 8 cycles");
    end
    rd1(32'h004, g, v, d, e);
    checks++; if ({v, d} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL rst_preserved1 got v%b %h exp v1 deadbeef", v, d); end
  endtask

`ifdef ITCM_PARITY_EN
  task automatic test_parity;
    logic g, v, e; logic [31:0] d;
    par_flip = 1'b1;
    wr1(32'h030, 32'h1234_5678, 4'hF);
    par_flip = 1'b0;
    rd1(32'h030, g, v, d, e);
    checks++; if ({v, e, d} !== {2'b11, 32'h1234_5678}) begin
      errors++; $display("FAIL parity_flip got v%b e%b %h exp v1 e1 12345678", v, e, d); end
    wr1(32'h034, 32'h1234_5678, 4'hF);
    rd1(32'h034, g, v, d, e);
    checks++; if ({v, e} !== 2'b10) begin errors++; $display("FAIL parity_clean got v%b e%b exp v1 e0", v, e); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    b_rd_req = 1'b0; b_rd_addr = '0; b_rd_ready = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_strb = '0;
`ifdef ITCM_PARITY_EN
    par_flip = 1'b0; b_par_flip = 1'b0;
`endif
    test_reset();
    test_basic();
    test_illegal();
    test_strobe();
    test_rbw();
    test_backpressure();
    test_reset_inflight();
`ifdef ITCM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
